// File: rtl/digit_code_lock.sv
// digit_code_lock: serial digit-code checker with a try limit and a timed lockout.
// Digits arrive one per enter strobe. A sticky mismatch flag carries earlier
// digit errors through to the final-digit decision, so the result is only
// revealed once the whole code has been entered.
module digit_code_lock #(
  parameter int                          DIGITS         = 4,
  parameter int                          DIGIT_W        = 4,
  parameter logic [DIGITS*DIGIT_W-1:0]   CODE           = 16'h1234,
  parameter int                          MAX_TRIES      = 3,
  parameter int                          UNLOCK_CYCLES  = 50000000,
  parameter int                          LOCKOUT_CYCLES = 250000000
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [DIGIT_W-1:0]               digit_in,
  input  logic                             enter,
  input  logic                             clear,
  output logic                             unlocked,
  output logic                             fail,
  output logic                             locked_out,
  output logic [$clog2(DIGITS+1)-1:0]      digit_count,
  output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left
);

  localparam int CW   = $clog2(DIGITS+1);
  localparam int TRW  = $clog2(MAX_TRIES+1);
  localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX+1);

  typedef enum logic [1:0] {ENTRY, UNLOCK, LOCKOUT} state_t;

  state_t                          state, state_n;
  logic [CW-1:0]                   cnt_n;
  logic [TRW-1:0]                  tries_n;
  logic                            mism, mism_n;
  logic                            fail_n;
  logic [TW-1:0]                   timer, timer_n;
  logic [DIGITS-1:0][DIGIT_W-1:0]  code_dig;
  logic [DIGIT_W-1:0]              ref_dig;
  logic                            hit, last;

  // Unpack the reference code; index 0 is the most-significant slice.
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    assign code_dig[i] = CODE[(DIGITS-1-i)*DIGIT_W +: DIGIT_W];
  end

  // Select the reference digit for the current position (loop avoids an index width mismatch).
  always_comb begin
    ref_dig = '0;
    for (int i = 0; i < DIGITS; i++)
      if (digit_count == CW'(i)) ref_dig = code_dig[i];
  end

  assign hit  = (digit_in == ref_dig);
  assign last = (digit_count == CW'(DIGITS-1));

  // State and datapath registers; reset aborts any attempt, unlock or lockout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ENTRY;
      digit_count <= '0;
      tries_left  <= TRW'(MAX_TRIES);
      mism        <= 1'b0;
      fail        <= 1'b0;
      timer       <= '0;
    end else begin
      state       <= state_n;
      digit_count <= cnt_n;
      tries_left  <= tries_n;
      mism        <= mism_n;
      fail        <= fail_n;
      timer       <= timer_n;
    end
  end

  // Next-state logic. Timers load N-1 on entry so the state lasts exactly N cycles.
  always_comb begin
    state_n = state;
    cnt_n   = digit_count;
    tries_n = tries_left;
    mism_n  = mism;
    timer_n = timer;
    fail_n  = 1'b0;
    unique case (state)
      ENTRY: begin
        if (clear) begin
          cnt_n  = '0;
          mism_n = 1'b0;
        end else if (enter) begin
          if (!last) begin
            cnt_n  = digit_count + CW'(1);
            mism_n = mism | ~hit;
          end else begin
            cnt_n  = '0;
            mism_n = 1'b0;
            if (hit && !mism) begin
              state_n = UNLOCK;
              timer_n = TW'(UNLOCK_CYCLES-1);
              tries_n = TRW'(MAX_TRIES);
            end else if (tries_left > TRW'(1)) begin
              fail_n  = 1'b1;
              tries_n = tries_left - TRW'(1);
            end else begin
              fail_n  = 1'b1;
              tries_n = '0;
              state_n = LOCKOUT;
              timer_n = TW'(LOCKOUT_CYCLES-1);
            end
          end
        end
      end
      UNLOCK: begin
        if (timer == '0) begin
          state_n = ENTRY;
          cnt_n   = '0;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      LOCKOUT: begin
        if (timer == '0) begin
          state_n = ENTRY;
          tries_n = TRW'(MAX_TRIES);
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      default: state_n = ENTRY;
    endcase
  end

  assign unlocked   = (state == UNLOCK);
  assign locked_out = (state == LOCKOUT);

endmodule

// File: tb/tb_digit_code_lock.sv
// Directed bench for digit_code_lock with a 2-digit code 9,0.
module tb_digit_code_lock;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] digit_in;
  logic       enter, clear;
  logic       unlocked, fail, locked_out;
  logic [1:0] digit_count, tries_left;
  int checks = 0;
  int errors = 0;

  digit_code_lock #(
    .DIGITS(2), .DIGIT_W(4), .CODE(8'h90), .MAX_TRIES(3),
    .UNLOCK_CYCLES(4), .LOCKOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .digit_in(digit_in), .enter(enter), .clear(clear),
    .unlocked(unlocked), .fail(fail), .locked_out(locked_out),
    .digit_count(digit_count), .tries_left(tries_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    digit_in = d; enter = 1'b1;
    tick();
    enter = 1'b0;
  endtask

  task automatic status(input string tag, input logic u, input logic f, input logic l,
                        input logic [1:0] c, input logic [1:0] t);
    chk({tag, ".unlocked"}, 32'(u), 32'(unlocked));
    chk({tag, ".fail"},     32'(fail), 32'(f));
    chk({tag, ".locked"},   32'(locked_out), 32'(l));
    chk({tag, ".count"},    32'(digit_count), 32'(c));
    chk({tag, ".tries"},    32'(tries_left), 32'(t));
  endtask

  initial begin
    reset_n = 1'b0; digit_in = '0; enter = 1'b0; clear = 1'b0;
    #12;
    status("reset", 0, 0, 0, 0, 3);
    chk("reset.unlocked_low", 32'(unlocked), 32'd0);
    reset_n = 1'b1;

    // 1: correct code unlocks for exactly 4 cycles; 3: entries ignored meanwhile
    press(4'h9); status("t1.d1", 0, 0, 0, 1, 3);
    press(4'h0); status("t1.open1", 1, 0, 0, 0, 3);
    for (int i = 0; i < 3; i++) begin
      digit_in = (i == 1) ? 4'h0 : 4'h9; enter = 1'b1;
      tick();
      status("t3.unlock_hold", 1, 0, 0, 0, 3);
    end
    enter = 1'b0;
    tick(); status("t1.closed", 0, 0, 0, 0, 3);

    // 2: three wrong codes -> lockout
    press(4'h9); press(4'h1); status("t2.fail1", 0, 1, 0, 0, 2);
    tick();                   status("t2.pulse1", 0, 0, 0, 0, 2);
    press(4'h9); press(4'h1); status("t2.fail2", 0, 1, 0, 0, 1);
    tick();
    press(4'h9); press(4'h1); status("t2.lock", 0, 1, 1, 0, 0);
    for (int i = 0; i < 7; i++) begin
      digit_in = (i % 2 == 0) ? 4'h9 : 4'h0; enter = 1'b1;
      tick();
      status("t3.lock_hold", 0, 0, 1, 0, 0);
    end
    enter = 1'b0;
    tick(); status("t2.lock_end", 0, 0, 0, 0, 3);

    // 4: clear discards partial entry; clear beats enter
    press(4'h9); status("t4.d1", 0, 0, 0, 1, 3);
    clear = 1'b1; tick(); clear = 1'b0;
    status("t4.clear", 0, 0, 0, 0, 3);
    press(4'h0); status("t4.d1b", 0, 0, 0, 1, 3);
    press(4'h9); status("t4.fail", 0, 1, 0, 0, 2);
    tick();
    clear = 1'b1; press(4'h9); clear = 1'b0;
    status("t4.clr_enter", 0, 0, 0, 0, 2);

    // 5: second failure then correct code restores tries; sticky mismatch
    press(4'h9); press(4'h1); status("t5.fail", 0, 1, 0, 0, 1);
    tick();
    press(4'hA); status("t5.hex_digit", 0, 0, 0, 1, 1);
    clear = 1'b1; tick(); clear = 1'b0;
    press(4'h9); press(4'h0); status("t5.open", 1, 0, 0, 0, 3);
    tick(); tick(); tick();   status("t5.open_last", 1, 0, 0, 0, 3);
    tick();                   status("t5.closed", 0, 0, 0, 0, 3);
    press(4'h1); status("t5.bad_first", 0, 0, 0, 1, 3);
    press(4'h0); status("t5.sticky", 0, 1, 0, 0, 2);
    tick();

    // 6: asynchronous reset mid-lockout
    press(4'h9); press(4'h1); status("t6.fail", 0, 1, 0, 0, 1);
    tick();
    press(4'h9); press(4'h1); status("t6.lock", 0, 1, 1, 0, 0);
    tick(); tick();
    #2; reset_n = 1'b0;
    #1; status("t6.async_rst", 0, 0, 0, 0, 3);
    #1; reset_n = 1'b1;
    press(4'h9); press(4'h0); status("t6.open", 1, 0, 0, 0, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/digit_code_lock.md
Name: digit_code_lock

Overview:
- Sequential, parametrised code checker for the DE1-SoC.
- Accepts a multi-digit code one digit at a time: digit value on the switches, entry strobe from an edge-detected KEY press.
- Compares the entry against a compile-time code and reports unlock or failure.
- Enforces a try limit followed by a timed lockout. Instantiated under DE1_SoC; outputs drive LEDR and the HEX decoders.

Parameters:
DIGITS, 4, number of digits in the code (>=1)
DIGIT_W, 4, bits per digit (4 = BCD/hex digit)
CODE, 16'h1234, reference code, DIGITS*DIGIT_W bits; digit 0 is the most-significant slice
MAX_TRIES, 3, consecutive failed attempts before lockout (>=1)
UNLOCK_CYCLES, 50000000, cycles unlocked stays high (>=1)
LOCKOUT_CYCLES, 250000000, cycles of lockout (>=1)

Ports:
clk  input  1  system clock (CLOCK_50 at top level)
reset_n  input  1  asynchronous active-low reset
digit_in  input  DIGIT_W  digit value, sampled only on enter
enter  input  1  single-cycle strobe (already synchronised and edge-detected upstream)
clear  input  1  single-cycle strobe that discards the partial entry
unlocked  output  1  high while in UNLOCK
fail  output  1  one-cycle pulse per failed attempt
locked_out  output  1  high while in LOCKOUT
digit_count  output  $clog2(DIGITS+1)  digits entered in the current attempt
tries_left  output  $clog2(MAX_TRIES+1)  attempts remaining before lockout

Behaviour:
- One clock. Reset is asynchronous and active-low: the reset_n assertion clears all state immediately, independent of clk.
- Reset values:
  - State = ENTRY.
  - unlocked = 0, fail = 0, locked_out = 0.
  - digit_count = 0, tries_left = MAX_TRIES.
  - Mismatch flag = 0, timer = 0.
- Reset mid-attempt, mid-unlock or mid-lockout fully aborts the operation.
- States: ENTRY, UNLOCK, LOCKOUT. Outputs are registered.
- ENTRY:
  - enter with digit_count < DIGITS-1: compare digit_in against the CODE slice at index digit_count. A mismatch sets the sticky mismatch flag. digit_count increments.
  - enter with digit_count == DIGITS-1 (final digit): the final-digit compare is combined with the mismatch flag.
    - Pass: next edge enters UNLOCK; unlocked = 1; tries_left reloads to MAX_TRIES.
    - Fail, tries_left > 1: fail = 1 for exactly the next cycle; tries_left decrements; stay in ENTRY.
    - Fail, tries_left == 1: fail = 1 for one cycle, and on the same edge go to LOCKOUT with locked_out = 1 and tries_left = 0.
    - In every case, digit_count and the mismatch flag clear.
  - clear: digit_count = 0 and mismatch flag = 0 on the next edge. tries_left is unchanged, and clear does not count as an attempt.
  - clear and enter in the same cycle: clear wins and the digit is discarded.
  - Latency: outcome is visible 1 cycle after the final enter.
- UNLOCK:
  - unlocked is high for exactly UNLOCK_CYCLES cycles.
  - Then return to ENTRY with digit_count = 0.
  - enter and clear are ignored.
- LOCKOUT:
  - locked_out is high for exactly LOCKOUT_CYCLES cycles.
  - Then return to ENTRY with tries_left = MAX_TRIES.
  - enter and clear are ignored.
- Timer width: $clog2(max(UNLOCK_CYCLES, LOCKOUT_CYCLES)+1). The timer loads on state entry and counts down; the state exits on the cycle the count reaches its end. No wrap-around.
- A success resets the fail history; only consecutive failures accumulate.
- Digit values outside BCD (e.g. 4'hA) are compared literally.
- DIGITS=1 degenerates correctly: every enter is the final digit.
- fail is never high in the same cycle as unlocked.

Test Plan:
Bench parameters: DIGITS=2, CODE=8'h90, MAX_TRIES=3, UNLOCK_CYCLES=4, LOCKOUT_CYCLES=8.
1. Reset, enter 9, enter 0 -> unlocked=1 starting the cycle after the 2nd enter, high exactly 4 cycles; tries_left=3; digit_count 0->1->0.
2. enter 9, enter 1 -> fail pulse of 1 cycle; tries_left=2; unlocked stays 0. Repeat -> tries_left=1. Third wrong code -> fail and locked_out both go high on the same cycle; tries_left=0; locked_out high 8 cycles, then tries_left=3.
3. During LOCKOUT and UNLOCK, apply enter with 9 and 0 -> ignored; digit_count stays 0; no extra fail or unlock.
4. enter 9, then clear, then enter 0, enter 9 -> fail (entry was 0,9); tries_left decremented by exactly 1. Also apply clear and enter together -> digit_count=0.
5. Two failures, then correct code -> unlock, and tries_left returns to 3. Wrong-first-digit (enter 1) then correct second digit (0) -> fail, proving the sticky mismatch flag.
6. Pulse reset_n low asynchronously mid-LOCKOUT (between clock edges) -> locked_out=0 and tries_left=3 immediately; a correct code afterwards unlocks.
